// File: rtl/od_counter_bank_if.sv
// Control and status bundle for od_counter_bank: per-channel strobes/data in, counts and flags out.
// The master side drives enable/down/load/load_value/clear; the slave side is the counter bank.
interface od_counter_bank_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       down;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_value;
    logic [CHANNELS-1:0]       clear;
    logic [CHANNELS*WIDTH-1:0] counter_output;
    logic [CHANNELS-1:0]       terminal;
    logic [CHANNELS-1:0]       overflow;
    logic                      tick;

    modport master (
        output enable, down, load, load_value, clear,
        input  counter_output, terminal, overflow, tick
    );

    modport slave (
        input  enable, down, load, load_value, clear,
        output counter_output, terminal, overflow, tick
    );
endinterface

// File: rtl/od_counter_bank.sv
// CHANNELS independent WIDTH-bit up/down counters sharing one free-running prescaler.
// Define OD_COUNTER_SAT_EN to make boundary steps saturate instead of wrapping.
module od_counter_bank #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    od_counter_bank_if.slave  bus
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;
    logic             tick;

    // With PRESCALE=1 pre sits at 0 == PRE_LAST, so tick is permanently high.
    always_comb begin
        pre_next = (pre_reg == PRE_LAST) ? '0 : pre_reg + PRE_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    assign tick     = (pre_reg == PRE_LAST);
    assign bus.tick = tick;

    logic [CHANNELS*WIDTH-1:0] count_all;
    logic [CHANNELS-1:0]       terminal_all;
    logic [CHANNELS-1:0]       overflow_all;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] count_reg;
            logic [WIDTH-1:0] count_next;
            logic [WIDTH-1:0] stepped;
            logic [WIDTH-1:0] load_slice;
            logic             terminal_reg;
            logic             terminal_next;
            logic             overflow_reg;
            logic             overflow_next;
            logic             step;
            logic             at_boundary;

            assign load_slice  = bus.load_value[gi*WIDTH +: WIDTH];
            assign step        = bus.enable[gi] & tick & ~bus.load[gi] & ~bus.clear[gi];
            assign at_boundary = bus.down[gi] ? (count_reg == '0) : (count_reg == '1);
            assign stepped     = bus.down[gi] ? count_reg - WIDTH'(1) : count_reg + WIDTH'(1);

            // Priority: clear > load > step > hold; terminal is a single-cycle pulse.
            always_comb begin
                count_next    = count_reg;
                terminal_next = 1'b0;
                overflow_next = overflow_reg;
                if (bus.clear[gi]) begin
                    count_next    = '0;
                    overflow_next = 1'b0;
                end else if (bus.load[gi]) begin
                    count_next = load_slice;
                end else if (step) begin
                    if (at_boundary) begin
                        terminal_next = 1'b1;
                        overflow_next = 1'b1;
                    end
`ifdef OD_COUNTER_SAT_EN
                    if (!at_boundary) begin
                        count_next = stepped;
                    end
`else
                    count_next = stepped;
`endif
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_reg    <= '0;
                    terminal_reg <= 1'b0;
                    overflow_reg <= 1'b0;
                end else begin
                    count_reg    <= count_next;
                    terminal_reg <= terminal_next;
                    overflow_reg <= overflow_next;
                end
            end

            assign count_all[gi*WIDTH +: WIDTH] = count_reg;
            assign terminal_all[gi]             = terminal_reg;
            assign overflow_all[gi]             = overflow_reg;
        end
    endgenerate

    assign bus.counter_output = count_all;
    assign bus.terminal       = terminal_all;
    assign bus.overflow       = overflow_all;
endmodule

// File: tb/tb_od_counter_bank.sv
// Bench for od_counter_bank: two instances (PRESCALE=1 and 3), directed tables, random vs model.
// Expectations follow OD_COUNTER_SAT_EN when it is defined for the build.
module tb_od_counter_bank;
    localparam int W = 4;
    localparam int C = 2;
    localparam int VW = C * W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    od_counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bus1 ();
    od_counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bus3 ();

    od_counter_bank #(.WIDTH(W), .CHANNELS(C), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    od_counter_bank #(.WIDTH(W), .CHANNELS(C), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    typedef struct {
        logic [C-1:0]  en;
        logic [C-1:0]  dn;
        logic [C-1:0]  ld;
        logic [C-1:0]  clr;
        logic [VW-1:0] lv;
        logic [VW-1:0] cnt;
        logic [C-1:0]  term;
        logic [C-1:0]  ovf;
    } vec_t;

    vec_t tbl[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain integers per DUT (index 0 = PRESCALE 1, index 1 = PRESCALE 3).
    int m_cnt[2][C];
    bit m_term[2][C];
    bit m_ovf[2][C];
    int m_cyc[2];
    int m_p[2] = '{1, 3};

    function automatic vec_t mkv(input logic [C-1:0] en, input logic [C-1:0] dn,
                                 input logic [C-1:0] ld, input logic [VW-1:0] lv,
                                 input logic [C-1:0] clr, input logic [VW-1:0] cnt,
                                 input logic [C-1:0] term, input logic [C-1:0] ovf);
        vec_t v;
        v.en = en; v.dn = dn; v.ld = ld; v.lv = lv; v.clr = clr;
        v.cnt = cnt; v.term = term; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cyc[d] = 0;
            for (int ch = 0; ch < C; ch++) begin
                m_cnt[d][ch] = 0;
                m_term[d][ch] = 1'b0;
                m_ovf[d][ch] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input int d, input logic [C-1:0] en, input logic [C-1:0] dn,
                              input logic [C-1:0] ld, input logic [C-1:0] clr,
                              input logic [VW-1:0] lv);
        bit tk;
        int top;
        tk = (m_cyc[d] % m_p[d]) == (m_p[d] - 1);
        top = (1 << W) - 1;
        for (int ch = 0; ch < C; ch++) begin
            m_term[d][ch] = 1'b0;
            if (clr[ch]) begin
                m_cnt[d][ch] = 0;
                m_ovf[d][ch] = 1'b0;
            end else if (ld[ch]) begin
                m_cnt[d][ch] = int'(lv[ch*W +: W]);
            end else if (en[ch] && tk) begin
                if ((dn[ch] && m_cnt[d][ch] == 0) || (!dn[ch] && m_cnt[d][ch] == top)) begin
                    m_term[d][ch] = 1'b1;
                    m_ovf[d][ch] = 1'b1;
`ifndef OD_COUNTER_SAT_EN
                    m_cnt[d][ch] = dn[ch] ? top : 0;
`endif
                end else begin
                    m_cnt[d][ch] = dn[ch] ? m_cnt[d][ch] - 1 : m_cnt[d][ch] + 1;
                end
            end
        end
        m_cyc[d]++;
    endtask

    task automatic check_dut(input int d, input int n);
        logic [VW-1:0] ec;
        logic [C-1:0] et, eo;
        logic [VW-1:0] gc;
        logic [C-1:0] gt, go;
        logic gk, ek;
        for (int ch = 0; ch < C; ch++) begin
            ec[ch*W +: W] = W'(m_cnt[d][ch]);
            et[ch] = m_term[d][ch];
            eo[ch] = m_ovf[d][ch];
        end
        ek = (m_cyc[d] % m_p[d]) == (m_p[d] - 1);
        if (d == 0) begin
            gc = bus1.counter_output; gt = bus1.terminal; go = bus1.overflow; gk = bus1.tick;
        end else begin
            gc = bus3.counter_output; gt = bus3.terminal; go = bus3.overflow; gk = bus3.tick;
        end
        check($sformatf("rnd%0d_p%0d_count", n, m_p[d]), 32'(gc), 32'(ec));
        check($sformatf("rnd%0d_p%0d_terminal", n, m_p[d]), 32'(gt), 32'(et));
        check($sformatf("rnd%0d_p%0d_overflow", n, m_p[d]), 32'(go), 32'(eo));
        check($sformatf("rnd%0d_p%0d_tick", n, m_p[d]), 32'(gk), 32'(ek));
    endtask

    task automatic idle_inputs();
        bus1.enable = '0; bus1.down = '0; bus1.load = '0; bus1.clear = '0; bus1.load_value = '0;
        bus3.enable = '0; bus3.down = '0; bus3.load = '0; bus3.clear = '0; bus3.load_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        // Directed table on the PRESCALE=1 instance; ch0 is the low nibble.
`ifdef OD_COUNTER_SAT_EN
        tbl.push_back(mkv(2'b00, 2'b00, 2'b01, 8'h0F, 2'b00, 8'h0F, 2'b00, 2'b00));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 8'h0F, 2'b01, 2'b01));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 8'h0F, 2'b01, 2'b01));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 8'h0F, 2'b01, 2'b01));
        tbl.push_back(mkv(2'b00, 2'b00, 2'b01, 8'h00, 2'b00, 8'h00, 2'b00, 2'b01));
        tbl.push_back(mkv(2'b01, 2'b01, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 2'b01));
        tbl.push_back(mkv(2'b11, 2'b11, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 2'b11));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b01, 8'h09, 2'b01, 8'h00, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b01, 8'h09, 2'b00, 8'h09, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b00, 2'b00, 2'b00, 8'h00, 2'b10, 8'h09, 2'b00, 2'b00));
`else
        tbl.push_back(mkv(2'b00, 2'b00, 2'b01, 8'h0E, 2'b00, 8'h0E, 2'b00, 2'b00));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 8'h0F, 2'b00, 2'b00));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 8'h00, 2'b01, 2'b01));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b00, 8'h01, 2'b00, 2'b01));
        tbl.push_back(mkv(2'b00, 2'b00, 2'b10, 8'h10, 2'b00, 8'h11, 2'b00, 2'b01));
        tbl.push_back(mkv(2'b10, 2'b10, 2'b00, 8'h00, 2'b00, 8'h01, 2'b00, 2'b01));
        tbl.push_back(mkv(2'b10, 2'b10, 2'b00, 8'h00, 2'b00, 8'hF1, 2'b10, 2'b11));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b01, 8'h09, 2'b01, 8'hF0, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b01, 8'h09, 2'b00, 8'hF9, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 8'hF9, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b00, 2'b00, 2'b01, 8'h0F, 2'b00, 8'hFF, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b01, 2'b00, 2'b00, 8'h00, 2'b01, 8'hF0, 2'b00, 2'b10));
        tbl.push_back(mkv(2'b00, 2'b00, 2'b00, 8'h00, 2'b10, 8'h00, 2'b00, 2'b00));
`endif

        // Reset state, both instances.
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("reset_count_p1", 32'(bus1.counter_output), 32'h0);
        check("reset_term_p1", 32'(bus1.terminal), 32'h0);
        check("reset_ovf_p1", 32'(bus1.overflow), 32'h0);
        check("reset_tick_p1", 32'(bus1.tick), 32'h1);
        check("reset_count_p3", 32'(bus3.counter_output), 32'h0);
        check("reset_tick_p3", 32'(bus3.tick), 32'h0);
        $display("reset: count1=%h count3=%h tick1=%b tick3=%b",
                 bus1.counter_output, bus3.counter_output, bus1.tick, bus3.tick);

        // PRESCALE=3 from release: count advances on every third edge.
        reset = 1'b0;
        bus3.enable = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("p3_count_cyc%0d", k), 32'(bus3.counter_output[W-1:0]), 32'(k / 3));
            check($sformatf("p3_tick_cyc%0d", k), 32'(bus3.tick), 32'((k % 3) == 2));
            $display("p3 cycle %0d: count=%0d tick=%b", k, bus3.counter_output[W-1:0], bus3.tick);
        end
        bus3.enable = '0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus1.enable = tbl[i].en;
            bus1.down = tbl[i].dn;
            bus1.load = tbl[i].ld;
            bus1.load_value = tbl[i].lv;
            bus1.clear = tbl[i].clr;
            @(negedge clk);
            check($sformatf("tbl%0d_count", i), 32'(bus1.counter_output), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_terminal", i), 32'(bus1.terminal), 32'(tbl[i].term));
            check($sformatf("tbl%0d_overflow", i), 32'(bus1.overflow), 32'(tbl[i].ovf));
            $display("tbl %0d: count=%h terminal=%b overflow=%b", i,
                     bus1.counter_output, bus1.terminal, bus1.overflow);
        end

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            logic [C-1:0] en1, dn1, ld1, cl1, en3, dn3, ld3, cl3;
            logic [VW-1:0] lv1, lv3;
            for (int ch = 0; ch < C; ch++) begin
                en1[ch] = ($urandom_range(0, 3) != 0);
                dn1[ch] = ($urandom_range(0, 2) == 0);
                ld1[ch] = ($urandom_range(0, 9) == 0);
                cl1[ch] = ($urandom_range(0, 19) == 0);
                en3[ch] = ($urandom_range(0, 3) != 0);
                dn3[ch] = ($urandom_range(0, 2) == 0);
                ld3[ch] = ($urandom_range(0, 9) == 0);
                cl3[ch] = ($urandom_range(0, 19) == 0);
            end
            lv1 = VW'($urandom);
            lv3 = VW'($urandom);
            bus1.enable = en1; bus1.down = dn1; bus1.load = ld1; bus1.clear = cl1; bus1.load_value = lv1;
            bus3.enable = en3; bus3.down = dn3; bus3.load = ld3; bus3.clear = cl3; bus3.load_value = lv3;
            @(posedge clk);
            model_edge(0, en1, dn1, ld1, cl1, lv1);
            model_edge(1, en3, dn3, ld3, cl3, lv3);
            @(negedge clk);
            check_dut(0, n);
            check_dut(1, n);
            $display("rnd %0d: count1=%h term1=%b ovf1=%b count3=%h term3=%b ovf3=%b", n,
                     bus1.counter_output, bus1.terminal, bus1.overflow,
                     bus3.counter_output, bus3.terminal, bus3.overflow);
        end

        // Asynchronous reset between edges with counts 7 and 12.
        do_reset();
        bus1.load = 2'b11; bus1.load_value = {4'd12, 4'd7};
        bus3.load = 2'b11; bus3.load_value = {4'd12, 4'd7};
        @(negedge clk);
        check("pre_areset_count_p1", 32'(bus1.counter_output), 32'hC7);
        check("pre_areset_count_p3", 32'(bus3.counter_output), 32'hC7);
        bus1.load = '0; bus3.load = '0;
        bus1.enable = 2'b11; bus3.enable = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        check("areset_count_p1", 32'(bus1.counter_output), 32'h0);
        check("areset_term_p1", 32'(bus1.terminal), 32'h0);
        check("areset_ovf_p1", 32'(bus1.overflow), 32'h0);
        check("areset_tick_p1", 32'(bus1.tick), 32'h1);
        check("areset_count_p3", 32'(bus3.counter_output), 32'h0);
        check("areset_tick_p3", 32'(bus3.tick), 32'h0);
        $display("async reset: count1=%h count3=%h", bus1.counter_output, bus3.counter_output);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
